debounce_event_ctrl: RTL and testbench
======================================

// Module: debounce_event_ctrl
// PURPOSE
//  Debounce scheduler for N raw push-buttons sharing one prescaler. A single
//  millisecond-class tick paces per-channel stability counters. Each filtered
//  edge becomes a queued press/release event. Events drain through one
//  valid/ready port under round-robin arbitration. Sits between board buttons
//  and UART/command logic; replaces per-button free-running debounce counters.
// PARAMETERS
//  N_BTN        4      number of button channels (1..16)
//  IDX_W        2      width of event index, >= clog2(N_BTN), min 1
//  TICK_CYCLES  50000  clocks per sample tick (1 ms at 50 MHz), >= 2
//  STABLE_TICKS 10     consecutive differing ticks needed to commit (1..255)
//  ACTIVE_LOW   1      1: pressed = 0 (idle 1); 0: pressed = 1 (idle 0)
// PORTS
//  i_Clk           in   1       system clock
//  i_Rst_n         in   1       asynchronous active-low reset
//  i_btn           in   N_BTN   raw asynchronous button levels
//  o_state         out  N_BTN   debounced levels
//  o_evt_valid     out  1       event available
//  i_evt_ready     in   1       consumer accepts event when valid&ready
//  o_evt_idx       out  IDX_W   channel of event
//  o_evt_press     out  1       1 = press edge, 0 = release edge
//  o_overflow      out  1       sticky: a pending event was overwritten
//  i_clr_overflow  in   1       clears o_overflow
// BEHAVIOUR
//  Reset (async assert, sync release): sync flops and o_state = idle level
//   (ACTIVE_LOW ? 1 : 0); prescaler, counters, pend, rr pointer = 0;
//   o_evt_valid = 0, o_evt_idx = 0, o_evt_press = 0, o_overflow = 0.
//   Reset mid-operation drops all counts, pending and presented events.
//  Input: 2-flop synchronizer per channel; only sync'd value s[i] is used.
//  Prescaler: counts 0..TICK_CYCLES-1, wraps; tick = 1 cycle on the wrap.
//  Channel i, tick cycles only (counters hold otherwise):
//   s[i]==o_state[i]             -> cnt[i] <= 0
//   s[i]!=o_state[i], cnt<ST-1   -> cnt[i] <= cnt[i]+1
//   s[i]!=o_state[i], cnt==ST-1  -> commit: o_state[i]<=s[i], cnt[i]<=0,
//                                   pend[i]<=1, dir[i]<=(s[i] is pressed)
//  Commit latency: STABLE_TICKS consecutive ticks observing the new level;
//   raw edge to o_state = 2 clk + (ST-1..ST) tick periods.
//  Commit while pend[i] already 1 and not granted that cycle: dir[i]
//   overwritten with newest, o_overflow <= 1.
//  Output register loads when !o_evt_valid or (valid & ready) same cycle:
//   grant = first pend[j] searching j = rr, rr+1, .. wrapping at N_BTN;
//   load idx=j, press=dir[j], valid=1, clear pend[j], rr <= j+1 (wrap).
//   No pend -> valid<=0 on accept. Event visible 1 clk after commit.
//  Same-cycle commit and grant on one channel: grant takes old dir; pend
//   stays set with new dir; no overflow.
//  valid & !ready: idx/press/valid held stable (no drop, no change).
//  Back-to-back: ready held 1 gives one event per clock.
//  o_overflow: set has priority over i_clr_overflow in the same cycle.
// TESTING (bench uses TICK_CYCLES=4, STABLE_TICKS=3, N_BTN=4, ACTIVE_LOW=1)
//  Reset with i_btn=4'hF -> o_state=4'hF, valid=0, overflow=0, idx=0.
//  i_btn[0] 1->0 held, ready=1 -> o_state[0]=0 within 2+12 clk; one event
//   idx=0 press=1 for exactly 1 clk; release back -> idx=0 press=0.
//  i_btn[1] low for 6 clk then high (under 3 ticks) -> o_state, valid never
//   change.
//  i_btn[0],[2] low same cycle, ready=0 -> valid with idx=0; ready=1 ->
//   idx=0 then idx=2 on consecutive clks; next ch0 event after ch2 wins rr.
//  ready=0, ch1 press then release both committed -> o_overflow=1; on
//   ready: single event idx=1 press=0; i_clr_overflow -> o_overflow=0.
//  Assert i_Rst_n low while valid=1 and cnt nonzero -> all outputs at reset
//   values immediately; no stale event after release.

Source files
------------

// File: rtl/debounce_event_ctrl.sv
// Debounce scheduler: N synchronized buttons share one sample prescaler; each
// committed edge is queued per channel and drained round-robin over valid/ready.
module debounce_event_ctrl #(
    parameter int N_BTN        = 4,
    parameter int IDX_W        = 2,
    parameter int TICK_CYCLES  = 50000,
    parameter int STABLE_TICKS = 10,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_state,
    output logic             o_evt_valid,
    input  logic             i_evt_ready,
    output logic [IDX_W-1:0] o_evt_idx,
    output logic             o_evt_press,
    output logic             o_overflow,
    input  logic             i_clr_overflow
);

    localparam int               PW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_CYCLES - 1);
    localparam logic [7:0]       CNT_MAX   = 8'(STABLE_TICKS - 1);
    localparam logic [N_BTN-1:0] IDLE      = (ACTIVE_LOW != 0) ? '1 : '0;

    logic             rst_meta, rst_n;
    logic [N_BTN-1:0] sync_q1, sync_q2;
    logic [PW-1:0]    presc;
    logic             tick;
    logic [7:0]       cnt [N_BTN];
    logic [N_BTN-1:0] pend, dir, commit, press_lvl, gnt_vec;
    logic [IDX_W-1:0] rr, gnt_idx, rr_next;
    logic             load, gnt_found, gnt_press, ovf_set;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    always_ff @(posedge i_Clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= IDLE;
            sync_q2 <= IDLE;
            presc   <= '0;
        end else begin
            sync_q1 <= i_btn;
            sync_q2 <= sync_q1;
            presc   <= tick ? '0 : presc + 1'b1;
        end
    end

    assign tick      = (presc == PRESC_MAX);
    assign press_lvl = (ACTIVE_LOW != 0) ? ~sync_q2 : sync_q2;
    assign load      = !o_evt_valid || i_evt_ready;

    always_comb begin
        commit = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            commit[i] = tick && (sync_q2[i] != o_state[i]) && (cnt[i] == CNT_MAX);
        end
    end

    // Round-robin search starting at rr over the pending set as of this cycle.
    always_comb begin
        int unsigned j;
        j         = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < N_BTN; k++) begin
            j = (32'(rr) + k) % N_BTN;
            if (!gnt_found && |(pend & (N_BTN'(1) << j))) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(j);
            end
        end
        gnt_vec   = (load && gnt_found) ? (N_BTN'(1) << gnt_idx) : '0;
        gnt_press = |(dir & (N_BTN'(1) << gnt_idx));
        rr_next   = ((32'(gnt_idx) + 1) >= N_BTN) ? '0 : gnt_idx + 1'b1;
        ovf_set   = |(commit & pend & ~gnt_vec);
    end

    always_ff @(posedge i_Clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_BTN; i++) cnt[i] <= '0;
        end else if (tick) begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                if (sync_q2[i] == o_state[i] || cnt[i] == CNT_MAX) cnt[i] <= '0;
                else                                               cnt[i] <= cnt[i] + 8'd1;
            end
        end
    end

    // A grant reads the old dir; a same-cycle commit re-arms pend with the new one.
    always_ff @(posedge i_Clk or negedge rst_n) begin
        if (!rst_n) begin
            o_state     <= IDLE;
            pend        <= '0;
            dir         <= '0;
            rr          <= '0;
            o_evt_valid <= 1'b0;
            o_evt_idx   <= '0;
            o_evt_press <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            o_state <= (o_state & ~commit) | (sync_q2 & commit);
            dir     <= (dir & ~commit) | (press_lvl & commit);
            pend    <= (pend & ~gnt_vec) | commit;
            if (load) begin
                o_evt_valid <= gnt_found;
                if (gnt_found) begin
                    o_evt_idx   <= gnt_idx;
                    o_evt_press <= gnt_press;
                    rr          <= rr_next;
                end
            end
            if (ovf_set)             o_overflow <= 1'b1;
            else if (i_clr_overflow) o_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_debounce_event_ctrl.sv
// Directed bench for debounce_event_ctrl with short tick/stability settings.
module tb_debounce_event_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn;
    logic [3:0] o_state;
    logic       valid, ready, press, ovf, clr;
    logic [1:0] idx;
    int         checks = 0;
    int         errors = 0;

    debounce_event_ctrl #(
        .N_BTN(4), .IDX_W(2), .TICK_CYCLES(4), .STABLE_TICKS(3), .ACTIVE_LOW(1)
    ) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_btn(btn), .o_state(o_state),
        .o_evt_valid(valid), .i_evt_ready(ready), .o_evt_idx(idx),
        .o_evt_press(press), .o_overflow(ovf), .i_clr_overflow(clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_evt(input string tag, input logic v, input logic [1:0] i, input logic p);
        check({tag, "_valid"}, 32'(valid), 32'(v));
        if (v) begin
            check({tag, "_idx"}, 32'(idx), 32'(i));
            check({tag, "_press"}, 32'(press), 32'(p));
        end
    endtask

    // Commit must land within 2 sync clocks plus 3 tick periods of 4 clocks.
    task automatic wait_state(input string tag, input logic [1:0] ch, input logic val);
        int n = 0;
        while (o_state[ch] !== val && n < 14) begin
            step();
            n++;
        end
        check(tag, 32'(o_state[ch]), 32'(val));
    endtask

    initial begin
        rst_n = 1'b0; btn = 4'hF; ready = 1'b0; clr = 1'b0;
        repeat (3) step();
        check("rst_state", 32'(o_state), 32'hF);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_idx", 32'(idx), 32'h0);
        check("rst_press", 32'(press), 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        rst_n = 1'b1;
        repeat (5) step();

        // single press / release on ch0 with ready held
        ready = 1'b1; btn[0] = 1'b0;
        wait_state("p0_commit", 2'd0, 1'b0);
        check("p0_pre_valid", 32'(valid), 32'h0);
        step(); check_evt("p0_evt", 1'b1, 2'd0, 1'b1);
        step(); check_evt("p0_gone", 1'b0, 2'd0, 1'b0);
        btn[0] = 1'b1;
        wait_state("r0_commit", 2'd0, 1'b1);
        step(); check_evt("r0_evt", 1'b1, 2'd0, 1'b0);
        step(); check_evt("r0_gone", 1'b0, 2'd0, 1'b0);

        // short glitch on ch1 never commits
        btn[1] = 1'b0;
        repeat (6) step();
        btn[1] = 1'b1;
        repeat (20) begin
            step();
            check("glitch_state", 32'(o_state), 32'hF);
            check("glitch_valid", 32'(valid), 32'h0);
        end

        // fresh reset so rr starts at 0, then simultaneous ch0/ch2 press
        rst_n = 1'b0; step(); step(); rst_n = 1'b1;
        repeat (5) step();
        ready = 1'b0; btn = 4'b1010;
        wait_state("dual_commit", 2'd0, 1'b0);
        check("dual_state", 32'(o_state), 32'hA);
        repeat (4) begin
            step(); check_evt("dual_hold", 1'b1, 2'd0, 1'b1);
        end
        ready = 1'b1;
        step(); check_evt("dual_second", 1'b1, 2'd2, 1'b1);
        step(); check_evt("dual_empty", 1'b0, 2'd0, 1'b0);

        // release both (rr now 3 wraps to ch0), then overflow ch1 behind it
        ready = 1'b0; btn = 4'hF;
        wait_state("rel_commit", 2'd0, 1'b1);
        check("rel_state", 32'(o_state), 32'hF);
        step(); check_evt("rel_first", 1'b1, 2'd0, 1'b0);
        btn[1] = 1'b0;
        wait_state("ov_press", 2'd1, 1'b0);
        check("ov_not_yet", 32'(ovf), 32'h0);
        btn[1] = 1'b1;
        wait_state("ov_release", 2'd1, 1'b1);
        check("ov_set", 32'(ovf), 32'h1);
        check_evt("ov_held", 1'b1, 2'd0, 1'b0);
        ready = 1'b1;
        step(); check_evt("ov_ch1", 1'b1, 2'd1, 1'b0);
        step(); check_evt("ov_ch2", 1'b1, 2'd2, 1'b0);
        step(); check_evt("ov_empty", 1'b0, 2'd0, 1'b0);
        check("ov_sticky", 32'(ovf), 32'h1);
        clr = 1'b1; step(); clr = 1'b0;
        check("ov_clear", 32'(ovf), 32'h0);

        // reset while an event is presented and a counter is running
        ready = 1'b0; btn[3] = 1'b0;
        wait_state("m_press3", 2'd3, 1'b0);
        step(); check_evt("m_evt3", 1'b1, 2'd3, 1'b1);
        btn[0] = 1'b0;
        repeat (6) step();
        #3 rst_n = 1'b0;
        #1;
        check("mr_state", 32'(o_state), 32'hF);
        check("mr_valid", 32'(valid), 32'h0);
        check("mr_idx", 32'(idx), 32'h0);
        check("mr_press", 32'(press), 32'h0);
        check("mr_ovf", 32'(ovf), 32'h0);
        step(); step();
        btn = 4'hF; rst_n = 1'b1;
        repeat (30) begin
            step();
            check("post_valid", 32'(valid), 32'h0);
            check("post_state", 32'(o_state), 32'hF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
